// File: rtl/fetch_queue_if.sv
// Fetch stage signal bundle: instruction-memory read port, redirect input and decode-queue handshake.
// master = fetch_queue side, slave = memory/execute/decode side.
interface fetch_queue_if #(
  parameter int INSTR_W = 16
);
  logic               imem_en;
  logic [7:0]         imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [7:0]         redirect_pc;
  logic               dq_valid;
  logic               dq_ready;
  logic [INSTR_W-1:0] dq_instr;
  logic [7:0]         dq_pc;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output dq_valid, dq_instr, dq_pc,
    input  dq_ready
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  dq_valid, dq_instr, dq_pc,
    output dq_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PCs, 1-cycle imem read, DEPTH-entry queue to decode; imem-to-decode latency 2 cycles.
// Issue is credit-limited (count+inflight < DEPTH) so decode backpressure stalls fetch; FETCH_PERF_EN adds perf counters.
module fetch_queue #(
  parameter int         DEPTH    = 4,
  parameter int         INSTR_W  = 16,
  parameter logic [3:0] HALT_OPC = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  fetch_queue_if.master     bus,
  output logic [7:0]        pc,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stall
`endif
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [7:0]         pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [7:0]      pc_q;
  logic [7:0]      ret_pc;
  logic            halted_q;

  logic            push;
  logic            pop;
  logic            halt_return;
  logic            issue;
  logic            dq_valid_w;
  logic [CW:0]     occupancy;

  // Return data is squashed by a same-cycle redirect; a returning HLT blocks the younger issue.
  always_comb begin
    push        = inflight && !bus.redirect_valid;
    halt_return = push && (bus.imem_rdata[INSTR_W-1 -: 4] == HALT_OPC);
    occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue       = !rst && !halted_q && !bus.redirect_valid &&
                  (occupancy < DEPTH_C) && !halt_return;
    dq_valid_w  = (count != '0);
    pop         = dq_valid_w && bus.dq_ready;
  end

  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc_q;
  assign bus.dq_valid  = dq_valid_w;
  assign bus.dq_instr  = mem[rd_ptr].instr;
  assign bus.dq_pc     = mem[rd_ptr].pc;
  assign pc            = pc_q;
  assign halted        = halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= 8'h00;
      ret_pc   <= 8'h00;
      inflight <= 1'b0;
      halted_q <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (bus.redirect_valid) begin
      pc_q     <= bus.redirect_pc;
      inflight <= 1'b0;
      halted_q <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_q   <= pc_q + 8'd1;
        ret_pc <= pc_q;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (halt_return) halted_q <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: bus.imem_rdata, pc: ret_pc};
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || bus.redirect_valid) begin
      perf_fetched <= 16'h0000;
      perf_stall   <= 16'h0000;
    end else begin
      if (push && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
      if (!halted_q && !issue && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic, checked by a sequential-stream scoreboard.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int DEPTH   = 4;
  localparam int INSTR_W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc;
  logic       halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
`endif

  fetch_queue_if #(.INSTR_W(INSTR_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .HALT_OPC(4'hF)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, 1-cycle read latency.
  logic [15:0] imem [256];
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= imem[bus.imem_addr];

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t exp_q[$];
  bit   ends_in_halt;
  bit   halt_checked;
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: after a restart, decode sees start, start+1, ... (mod 256) up to and including the first HLT.
  function automatic void restart_model(logic [7:0] start);
    logic [7:0] a;
    a = start;
    exp_q.delete();
    ends_in_halt = 1'b0;
    halt_checked = 1'b0;
    for (int n = 0; n < 512; n++) begin
      exp_q.push_back('{pc: a, instr: imem[a]});
      if (imem[a][15:12] == 4'hF) begin
        ends_in_halt = 1'b1;
        break;
      end
      a = a + 8'd1;
    end
  endfunction

  // Monitor: samples on the falling edge, i.e. the values the next rising edge will act on.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        restart_model(8'h00);
      end else begin
        if (bus.dq_valid && bus.dq_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_extra: got pc %0h expected no transfer", bus.dq_pc);
          end else begin
            e = exp_q.pop_front();
            check("dq_pc", 32'(bus.dq_pc), 32'(e.pc));
            check("dq_instr", 32'(bus.dq_instr), 32'(e.instr));
          end
        end else if (exp_q.size() == 0 && ends_in_halt && !halt_checked) begin
          halt_checked = 1'b1;
          check("halt_state", 32'({halted, bus.imem_en}), 32'(2'b10));
        end
        if (bus.redirect_valid) restart_model(bus.redirect_pc);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic do_redirect(logic [7:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick(1);
    bus.redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    bus.dq_ready       = 1'b1;
    rst                = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 16'h1000 + 16'(i);

    // Reset state
    tick(1);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_dq_valid", 32'(bus.dq_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_imem_en", 32'(bus.imem_en), 32'h0);

    // Streaming: release at cycle 3, first head two cycles after first issue
    tick(2);
    rst = 1'b0;
    #1;
    check("first_issue", 32'({bus.imem_en, bus.imem_addr}), 32'({1'b1, 8'h00}));
    tick(1);
    check("lat_not_yet", 32'(bus.dq_valid), 32'h0);
    tick(1);
    check("lat_valid", 32'(bus.dq_valid), 32'h1);
    check("lat_pc", 32'(bus.dq_pc), 32'h0);
    check("lat_instr", 32'(bus.dq_instr), 32'h1000);
    tick(12);

    // Backpressure: queue fills to DEPTH and fetch stalls
    bus.dq_ready = 1'b0;
    pulse_rst();
    tick(10);
    check("bp_valid", 32'(bus.dq_valid), 32'h1);
    check("bp_head", 32'(bus.dq_pc), 32'h0);
    check("bp_pc", 32'(pc), 32'h4);
    check("bp_stall", 32'(bus.imem_en), 32'h0);
    bus.dq_ready = 1'b1;
    tick(10);

    // Redirect with 3 queued entries and one read in flight
    bus.dq_ready = 1'b0;
    pulse_rst();
    tick(4);
    check("rd_pre_pc", 32'(pc), 32'h4);
    do_redirect(8'h40);
    check("rd_flushed", 32'(bus.dq_valid), 32'h0);
    check("rd_pc", 32'(pc), 32'h40);
    check("rd_issue", 32'({bus.imem_en, bus.imem_addr}), 32'({1'b1, 8'h40}));
    bus.dq_ready = 1'b1;
    tick(10);

    // Halt at PC 5, then redirect clears it
    imem[5] = 16'hF000;
    pulse_rst();
    tick(20);
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_pc", 32'(pc), 32'h6);
    check("halt_no_fetch", 32'(bus.imem_en), 32'h0);
    do_redirect(8'h00);
    check("halt_clear", 32'(halted), 32'h0);
    check("halt_refetch", 32'({bus.imem_en, bus.imem_addr}), 32'({1'b1, 8'h00}));
    tick(20);

    // PC wrap 255 -> 0
    imem[5] = 16'h1005;
    do_redirect(8'hFE);
    tick(12);

    // Reset with a full queue
    bus.dq_ready = 1'b0;
    tick(10);
    check("full_stall", 32'({bus.dq_valid, bus.imem_en}), 32'(2'b10));
    rst = 1'b1;
    tick(1);
    check("mid_rst_pc", 32'(pc), 32'h0);
    check("mid_rst_valid", 32'(bus.dq_valid), 32'h0);
    check("mid_rst_halted", 32'(halted), 32'h0);
    rst = 1'b0;
    #1;
    check("mid_rst_issue", 32'({bus.imem_en, bus.imem_addr}), 32'({1'b1, 8'h00}));
    bus.dq_ready = 1'b1;
    tick(10);

    // Randomized traffic with occasional HLT opcodes, redirects and resets
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 19) == 0) imem[i] = {4'hF, 12'($urandom)};
      else                            imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    end
    pulse_rst();
    for (int c = 0; c < 3000; c++) begin
      bus.dq_ready       = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 39) == 0);
      bus.redirect_pc    = 8'($urandom);
      rst                = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.dq_ready       = 1'b1;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
